uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that deserialises an asynchronous, LSB-first, 8N1-style serial line into parallel bytes for the ALU command path. It is the receive-side counterpart of the team's transmitter, using identical bit-timing parameters so the two loop back cycle-exactly. Each frame produces either a one-cycle valid pulse with the byte or a one-cycle framing-error pulse.

## Interface
- `BIT_RATE`, 9600, serial bit rate in bits/s.
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `PAYLOAD_BITS`, 8, data bits per frame (1–15).
- `STOP_BITS`, 1, stop bits per frame. Only the first stop bit is checked.
- Derived: `CYCLES_PER_BIT = (1_000_000_000/BIT_RATE)/(1_000_000_000/CLK_HZ)` (integer divisions); `HALF = CYCLES_PER_BIT/2`; counter width `1+$clog2(CYCLES_PER_BIT)`.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `uart_rxd` in 1: asynchronous serial input; idles high.
- `uart_rx_en` in 1: when high, new frames may start. Sampled in IDLE only.
- `uart_rx_busy` out 1: high whenever the state is not IDLE.
- `uart_rx_valid` out 1: one-cycle pulse when a good frame completes.
- `uart_rx_data` out PAYLOAD_BITS: last received byte. Held until the next frame completes.
- `uart_rx_frame_err` out 1: one-cycle pulse when the sampled stop bit is 0.

## Operation
- **Synchroniser:** `uart_rxd` passes through a 2-flop synchroniser (`rxs`); both flops reset to 1. All logic uses `rxs` only.
- **Cycle counter:**
  - Cleared on IDLE entry and at every sample event.
  - Increments by 1 per clock in START, RECV and STOP.
  - Sample event when the counter equals its target: HALF in START, CYCLES_PER_BIT in RECV and STOP.
- **FSM states:** IDLE, START, RECV, STOP.
  - IDLE: if `armed && uart_rx_en && rxs==0`, go to START. `armed` sets when `rxs==1` is seen in IDLE and clears on leaving IDLE.
  - START: at the sample event, if the sample is 0 go to RECV; otherwise treat it as a glitch and go to IDLE, with no output pulse.
  - RECV:
    - At each sample event, shift the sample into the MSB of the shift register (LSB-first line order) and increment the 4-bit bit counter.
    - At the PAYLOAD_BITS-th sample, go to STOP.
  - STOP: at the sample event, copy the shift register to `uart_rx_data` and go to IDLE.
    - If the sample is 1, pulse `uart_rx_valid`.
    - If the sample is 0, pulse `uart_rx_frame_err`. The data is still loaded.
- **Break condition:** after a framing error, the `armed` requirement means a low line held indefinitely produces no further frames until the line returns high.
- **Data-path independence:** `uart_rx_en` going low mid-frame does not abort the frame.
- **Reset values:** state IDLE, `armed` 0, counters 0, shift register 0, `uart_rx_data` 0, `uart_rx_valid` 0, `uart_rx_frame_err` 0, `uart_rx_busy` 0. Reset mid-frame discards the partial frame with no pulse.

## Timing
- **Bit period:** CYCLES_PER_BIT+1 clocks, equal to the transmitter's bit period.
- **Start-bit sample:** HALF+1 clocks after START entry, i.e. mid start bit.
- **Data and stop samples:** every CYCLES_PER_BIT+1 clocks after the start-bit sample.
- **Outputs:** `uart_rx_valid`, `uart_rx_frame_err` and `uart_rx_data` are registered. They assert in the clock after the stop-bit sample event, for exactly one cycle.
- **Input-to-detect latency:** from a `uart_rxd` falling edge to START entry is 3 clocks (2 synchroniser stages + IDLE decision).
- **Back-to-back frames:** IDLE is re-entered mid stop bit, so `armed` sets during the remainder of the stop bit. A start bit immediately following the stop bit is therefore accepted.
- **Simultaneous events:** `uart_rx_valid` and `uart_rx_frame_err` are never high together.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample is the 2-of-3 majority of `rxs` at counter values target−2, target−1 and target.
  - The decision is made at the target cycle, so timing is unchanged.
  - A 3-sample history register is added.
- `UART_RX_MAJORITY_EN` undefined: each sample is `rxs` at the target cycle only.

## Test plan
All tests use CLK_HZ=1_000_000, BIT_RATE=100_000 (CYCLES_PER_BIT=10, period 11 clocks, HALF=5).

- **Loopback:** team transmitter output drives `uart_rxd` and sends 0xA5 → exactly one `uart_rx_valid` pulse, `uart_rx_data`=0xA5, `uart_rx_frame_err` never high.
- **Back-to-back:** transmitter sends 0x00 then 0xFF with no idle gap → two valid pulses, data 0x00 then 0xFF.
- **Framing error / break:** drive frame 0x3C with stop bit 0, then hold the line low for 50 clocks → one `uart_rx_frame_err` pulse, `uart_rx_data`=0x3C, no valid pulse, `uart_rx_busy` stays 0 until the line returns high.
- **Glitch and enable:**
  - Drive `uart_rxd` low for 3 clocks → no pulses, FSM returns to IDLE.
  - With `uart_rx_en`=0, a full 0x55 frame → ignored.
- **Reset mid-frame:** assert `reset_n`=0 for 1 clock after 4 data bits → all outputs at reset values; the next frame 0x5A is received correctly.
- **Majority filter:** in frame 0x00, a 1-clock high pulse aligned to the bit-3 sample point:
  - With `UART_RX_MAJORITY_EN` defined → data 0x00.
  - Without it → data 0x08.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop synchroniser, mid-bit sampling, LSB-first deserialiser
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote on every bit sample.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err
);

  // Same integer arithmetic as the transmitter so both ends agree cycle-exactly.
  localparam int CYCLES_PER_BIT = (1_000_000_000 / BIT_RATE) / (1_000_000_000 / CLK_HZ);
  localparam int HALF           = CYCLES_PER_BIT / 2;
  localparam int COUNT_W        = 1 + $clog2(CYCLES_PER_BIT);

  localparam logic [COUNT_W-1:0] BIT_TGT  = COUNT_W'(CYCLES_PER_BIT);
  localparam logic [COUNT_W-1:0] HALF_TGT = COUNT_W'(HALF);
  localparam logic [3:0]         LAST_BIT = 4'(PAYLOAD_BITS - 1);
  // Only the first stop bit is ever checked; with no stop bit there is nothing to violate.
  localparam bit                 HAS_STOP = (STOP_BITS > 0);

  typedef enum logic [1:0] {IDLE, START, RECV, STOP} state_t;

  state_t                  state_q;
  logic                    rx_meta_q;
  logic                    rxs_q;
  logic                    armed_q;
  logic [COUNT_W-1:0]      cnt_q;
  logic [3:0]              bit_cnt_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    valid_q;
  logic                    frame_err_q;

  logic [COUNT_W-1:0]      target;
  logic                    sample_evt;
  logic                    sample;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rxs_q     <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Last two synchronised values; together with the live rxs they form the 3-sample vote window.
  logic [1:0] hist_q;

  // Keep a rolling history of rxs so the vote covers counts target-2 .. target.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs_q};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign sample = rxs_q;
`endif

  // Start bit is sampled at its middle; every later bit one full period after the previous one.
  assign target     = (state_q == START) ? HALF_TGT : BIT_TGT;
  assign sample_evt = (cnt_q == target);

  // Frame FSM with its counters, shift register and registered result pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          // A line stuck low (break) never re-arms until it has been seen high again.
          if (armed_q && uart_rx_en && !rxs_q) begin
            state_q <= START;
            armed_q <= 1'b0;
          end else if (rxs_q) begin
            armed_q <= 1'b1;
          end
        end
        START: begin
          if (sample_evt) begin
            cnt_q   <= '0;
            state_q <= sample ? IDLE : RECV;
          end else begin
            cnt_q <= cnt_q + COUNT_W'(1);
          end
        end
        RECV: begin
          if (sample_evt) begin
            cnt_q     <= '0;
            shift_q   <= (shift_q >> 1) | (PAYLOAD_BITS'(sample) << (PAYLOAD_BITS - 1));
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + COUNT_W'(1);
          end
        end
        STOP: begin
          if (sample_evt) begin
            cnt_q       <= '0;
            data_q      <= shift_q;
            valid_q     <= !HAS_STOP || sample;
            frame_err_q <= HAS_STOP && !sample;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + COUNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_rx_busy      = (state_q != IDLE);
  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx using a frame-level line model
module tb_uart_rx;

  localparam int BIT_CLKS = 11;  // CYCLES_PER_BIT+1 for 1 MHz clock, 100 kbit/s
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_busy;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_frame_err;

  int errors = 0;
  int checks = 0;

  logic [8:0] got_q[$];  // {is_frame_err, data}
  logic [8:0] exp_q[$];
  int         both_cnt = 0;
  logic       busy_seen = 1'b0;

  uart_rx #(
    .BIT_RATE    (100_000),
    .CLK_HZ      (1_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .uart_rxd         (uart_rxd),
    .uart_rx_en       (uart_rx_en),
    .uart_rx_busy     (uart_rx_busy),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_frame_err(uart_rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe result pulses away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (uart_rx_valid && uart_rx_frame_err) both_cnt++;
      if (uart_rx_valid) got_q.push_back({1'b0, uart_rx_data});
      if (uart_rx_frame_err) got_q.push_back({1'b1, uart_rx_data});
      if (uart_rx_busy) busy_seen = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start + 8 data (LSB first) + stop frame, one line value per clock.
  // glitch_c inverts the line for that single clock; n_clk truncates the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_c,
                            input int n_clk, input logic end_lvl);
    logic [9:0] bits;
    logic       v;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < n_clk; c++) begin
      v = bits[c / BIT_CLKS];
      if (c == glitch_c) v = ~v;
      uart_rxd = v;
      tick(1);
    end
    uart_rxd = end_lvl;
  endtask

  task automatic expect_ev(input logic is_err, input logic [7:0] d);
    exp_q.push_back({is_err, d});
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic [7:0] maj_exp;

    reset_n    = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    tick(3);
    chk("reset_busy", 32'(uart_rx_busy), 32'd0);
    chk("reset_valid", 32'(uart_rx_valid), 32'd0);
    chk("reset_ferr", 32'(uart_rx_frame_err), 32'd0);
    chk("reset_data", 32'(uart_rx_data), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Loopback-style single frame
    send_frame(8'hA5, 1'b1, -1, FRAME_CLKS, 1'b1);
    tick(5);
    expect_ev(1'b0, 8'hA5);
    chk("loop_data", 32'(uart_rx_data), 32'hA5);
    check_events("loopback");

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b1, -1, FRAME_CLKS, 1'b1);
    send_frame(8'hFF, 1'b1, -1, FRAME_CLKS, 1'b1);
    tick(5);
    expect_ev(1'b0, 8'h00);
    expect_ev(1'b0, 8'hFF);
    check_events("b2b");

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0, -1, FRAME_CLKS, 1'b0);
    busy_seen = 1'b0;
    tick(50);
    chk("break_busy", 32'(busy_seen), 32'd0);
    chk("ferr_data", 32'(uart_rx_data), 32'h3C);
    uart_rxd = 1'b1;
    tick(5);
    expect_ev(1'b1, 8'h3C);
    check_events("ferr");

    // Short low glitch: START entered, rejected, back to IDLE
    busy_seen = 1'b0;
    uart_rxd  = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(20);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_idle", 32'(uart_rx_busy), 32'd0);
    check_events("glitch");

    // Disabled receiver ignores a whole frame
    uart_rx_en = 1'b0;
    busy_seen  = 1'b0;
    tick(2);
    send_frame(8'h55, 1'b1, -1, FRAME_CLKS, 1'b1);
    tick(5);
    chk("dis_busy", 32'(busy_seen), 32'd0);
    check_events("disabled");
    uart_rx_en = 1'b1;
    tick(3);

    // Reset after four data bits, then a clean frame
    send_frame(8'h5A, 1'b1, -1, 5 * BIT_CLKS, 1'b1);
    chk("mid_busy", 32'(uart_rx_busy), 32'd1);
    reset_n = 1'b0;
    tick(1);
    chk("rst_busy", 32'(uart_rx_busy), 32'd0);
    chk("rst_valid", 32'(uart_rx_valid), 32'd0);
    chk("rst_ferr", 32'(uart_rx_frame_err), 32'd0);
    chk("rst_data", 32'(uart_rx_data), 32'd0);
    reset_n = 1'b1;
    tick(3);
    check_events("rst_discard");
    send_frame(8'h5A, 1'b1, -1, FRAME_CLKS, 1'b1);
    tick(5);
    expect_ev(1'b0, 8'h5A);
    check_events("after_rst");

    // One-clock high pulse on the bit-3 sample clock (index 6 of data bit 3)
    maj_exp = MAJ ? 8'h00 : 8'h08;
    send_frame(8'h00, 1'b1, BIT_CLKS * 4 + 6, FRAME_CLKS, 1'b1);
    tick(5);
    expect_ev(1'b0, maj_exp);
    check_events("majority");

    // Random frames, occasional bad stop bits, short random gaps
    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      gap  = stop ? int'($urandom_range(4)) : int'($urandom_range(4, 1));
      send_frame(d, stop, -1, FRAME_CLKS, 1'b1);
      expect_ev(!stop, d);
      tick(gap);
    end
    tick(10);
    check_events("random");

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
